sequence_detector: RTL

SEQUENCE_DETECTOR -- requirements
Module: sequence_detector

---
 rtl/seqdet_pkg.sv | 20 ++
 rtl/seqdet_shift_match.sv | 45 ++++
 rtl/sequence_detector.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/seqdet_pkg.sv
// Shared types and default parameters for the serial sequence detector.
// The lock FSM states and the missed-frame limit live here.
package seqdet_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  // Consecutive missed on-period matches that drop lock.
  localparam int MISS_LIMIT = 2;

  localparam int         DEF_PAT_LEN = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
  localparam int         DEF_PERIOD  = 8;
  localparam int         DEF_LOCK_N  = 3;
  localparam int         DEF_CNT_W   = 8;

endpackage

// File: rtl/seqdet_shift_match.sv
// Serial shift register, saturating fill counter and pattern comparator.
// SEQDET_OVERLAP_EN keeps the fill after a match so overlapping patterns are found.
module seqdet_shift_match
  import seqdet_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN)
) (
  input  logic clk,
  input  logic reset,
  input  logic din_valid,
  input  logic din,
  output logic hit
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] sr_q;
  logic [PAT_LEN-1:0] sr_d;
  logic [FILL_W-1:0]  fill_q;
  logic [FILL_W-1:0]  fill_d;

  // hit looks at the register as it will be after this edge's shift.
  always_comb begin
    sr_d   = {sr_q[PAT_LEN-2:0], din};
    fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    hit    = din_valid && (fill_d == FILL_FULL) && (sr_d == PATTERN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else if (din_valid) begin
      sr_q <= sr_d;
`ifdef SEQDET_OVERLAP_EN
      fill_q <= fill_d;
`else
      fill_q <= hit ? '0 : fill_d;
`endif
    end
  end

endmodule

// File: rtl/sequence_detector.sv
// Serial pattern detector with saturating match counter and a frame-lock FSM
// (HUNT -> SYNC -> LOCKED) that expects one match every PERIOD valid bits.
module sequence_detector
  import seqdet_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
  parameter int                 PERIOD  = DEF_PERIOD,
  parameter int                 LOCK_N  = DEF_LOCK_N,
  parameter int                 CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_count,
  output logic             match,
  output logic             locked,
  output logic [CNT_W-1:0] match_count,
  output lock_state_t      dbg_state
);

  localparam int PHASE_W = $clog2(PERIOD + 1);
  localparam int GOOD_W  = $clog2(LOCK_N + 1);
  localparam int MISS_W  = $clog2(MISS_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic               hit;
  lock_state_t        state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d, phase_inc;
  logic [GOOD_W-1:0]  good_q, good_d, good_inc;
  logic [MISS_W-1:0]  miss_q, miss_d, miss_inc;
  logic               at_period;
  logic               locked_d;

  seqdet_shift_match #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_shift_match (
    .clk       (clk),
    .reset     (reset),
    .din_valid (din_valid),
    .din       (din),
    .hit       (hit)
  );

  // FSM state register, including phase / good / miss bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
      phase_q <= '0;
      good_q  <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
    end
  end

  assign phase_inc = phase_q + 1'b1;
  assign good_inc  = good_q + 1'b1;
  assign miss_inc  = miss_q + 1'b1;
  // True when the bit arriving now is the PERIOD-th since the last accepted match.
  assign at_period = (phase_q == PHASE_W'(PERIOD - 1));

  // Next-state logic; everything holds while din_valid is low.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    good_d  = good_q;
    miss_d  = miss_q;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          phase_d = '0;
          good_d  = '0;
          miss_d  = '0;
          if (hit) begin
            state_d = SYNC;
            good_d  = GOOD_W'(1);
          end
        end
        SYNC: begin
          if (at_period) begin
            phase_d = '0;
            if (!hit) begin
              state_d = HUNT;
              good_d  = '0;
            end else begin
              good_d = good_inc;
              if (good_inc == GOOD_W'(LOCK_N)) begin
                state_d = LOCKED;
                miss_d  = '0;
              end
            end
          end else if (hit) begin
            good_d  = GOOD_W'(1);
            phase_d = '0;
          end else begin
            phase_d = phase_inc;
          end
        end
        LOCKED: begin
          // Off-phase matches are ignored here.
          if (at_period) begin
            phase_d = '0;
            if (hit) begin
              miss_d = '0;
            end else if (miss_inc == MISS_W'(MISS_LIMIT)) begin
              state_d = HUNT;
              miss_d  = '0;
              good_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end else begin
            phase_d = phase_inc;
          end
        end
        default: begin
          state_d = HUNT;
          phase_d = '0;
          good_d  = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

  // Output decode; locked is registered so it tracks state exactly.
  always_comb begin
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match  <= 1'b0;
      locked <= 1'b0;
    end else begin
      match  <= hit;
      locked <= locked_d;
    end
  end

  // A clear coinciding with a match leaves exactly that match counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_count <= '0;
    end else if (clr_count) begin
      match_count <= hit ? CNT_W'(1) : '0;
    end else if (hit && (match_count != CNT_MAX)) begin
      match_count <= match_count + 1'b1;
    end
  end

  assign dbg_state = state_q;

endmodule
